// File: rtl/fxp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fxp_pkg                                                   |
// | Purpose  : Shared fixed-point constants and helper functions.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fxp_pkg;

    localparam int c_default_width = 26;

    function automatic int fxp_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Signed range limits for a given width, returned as 64-bit values.
    function automatic longint fxp_max_signed(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint fxp_min_signed(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fxp_sat                                                   |
// | Purpose  : Reduce a wide signed sum to WIDTH bits with overflow flag;|
// |            clamps when FXP_ADD_TREE_SAT_EN is defined, else wraps.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int IN_W  = 30,
    parameter int WIDTH = c_default_width
) (
    input  logic [IN_W-1:0]  i_sum,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ovf
);

    // The value fits exactly when every bit from the WIDTH sign position up matches.
    logic [IN_W-WIDTH:0] w_head;
    assign w_head = i_sum[IN_W-1:WIDTH-1];
    assign o_ovf  = ~((&w_head) | ~(|w_head));

`ifdef FXP_ADD_TREE_SAT_EN
    localparam logic [WIDTH-1:0] c_max = WIDTH'(fxp_max_signed(WIDTH));
    localparam logic [WIDTH-1:0] c_min = WIDTH'(fxp_min_signed(WIDTH));

    always_comb begin
        o_data = i_sum[WIDTH-1:0];
        if (o_ovf) o_data = i_sum[IN_W-1] ? c_min : c_max;
    end
`else
    assign o_data = i_sum[WIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/fxp_add_tree.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fxp_add_tree                                              |
// | Purpose  : Pipelined NUM_IN-operand signed adder with per-operand    |
// |            negate, stall/flush; FXP_ADD_TREE_SAT_EN selects clamping.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fxp_add_tree
    import fxp_pkg::*;
#(
    parameter int WIDTH  = c_default_width,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_sub,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_ovf
);

    localparam int c_levels = fxp_clog2(NUM_IN);
    localparam int c_sum_w  = WIDTH + 1 + c_levels;

    logic [c_levels:0] r_vld;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_ovf;
    logic              w_adv;

    assign w_adv = ~stall & ~flush;

    // Flush clears valid bits only; stall freezes them.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
        end else if (!stall) begin
            r_vld       <= {r_vld[c_levels-1:0], in_valid};
            r_out_valid <= r_vld[c_levels];
        end
    end

    for (genvar k = 0; k <= c_levels; k++) begin : g_lvl
        localparam int c_w = WIDTH + 1 + k;
        localparam int c_n = NUM_IN >> k;

        logic [c_w-1:0] r_sum [c_n];

        if (k == 0) begin : g_in
            // One extra bit makes negating the most negative operand exact.
            logic [c_w-1:0] w_ext [c_n];

            always_comb begin
                for (int j = 0; j < c_n; j++) begin
                    w_ext[j] = {in_data[j*WIDTH + WIDTH - 1], in_data[j*WIDTH +: WIDTH]};
                end
            end

            always_ff @(posedge clk or negedge GlobalReset) begin
                if (!GlobalReset) begin
                    for (int j = 0; j < c_n; j++) r_sum[j] <= '0;
                end else if (in_valid && w_adv) begin
                    for (int j = 0; j < c_n; j++) r_sum[j] <= in_sub[j] ? -w_ext[j] : w_ext[j];
                end
            end
        end else begin : g_add
            always_ff @(posedge clk or negedge GlobalReset) begin
                if (!GlobalReset) begin
                    for (int j = 0; j < c_n; j++) r_sum[j] <= '0;
                end else if (r_vld[k-1] && w_adv) begin
                    for (int j = 0; j < c_n; j++) begin
                        r_sum[j] <= {g_lvl[k-1].r_sum[2*j][c_w-2],   g_lvl[k-1].r_sum[2*j]}
                                  + {g_lvl[k-1].r_sum[2*j+1][c_w-2], g_lvl[k-1].r_sum[2*j+1]};
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] w_red;
    logic             w_ovf;

    fxp_sat #(
        .IN_W  (c_sum_w),
        .WIDTH (WIDTH)
    ) u_sat (
        .i_sum  (g_lvl[c_levels].r_sum[0]),
        .o_data (w_red),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (r_vld[c_levels] && w_adv) begin
            r_out_data <= w_red;
            r_out_ovf  <= w_ovf;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
